kdarwin_rd_burst_ctrl: RTL and testbench



---
 rtl/kdarwin_pkg.sv | 26 ++
 rtl/kdarwin_rd_burst_ctrl_counter.sv | 40 ++++
 rtl/kdarwin_rd_burst_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_kdarwin_rd_burst_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kdarwin_pkg.sv
// Shared types and helpers for the KDarwin kernel memory front-end.
package kdarwin_pkg;

  // Read-burst scheduler state machine encoding.
  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN,
    DONE
  } rd_burst_state_t;

  // AXI4 bursts must not cross a 4 KiB boundary.
  localparam int LP_MAX_BURST_BYTES = 4096;

  // Integer ceiling division; den is always a non-zero elaboration constant.
  function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
    logic [63:0] q;
    q = num / den;
    if ((num % den) != 64'd0) begin
      q = q + 64'd1;
    end
    return q;
  endfunction

endpackage

// File: rtl/kdarwin_rd_burst_ctrl_counter.sv
// Generic up/down counter with load, used for burst bookkeeping.
// Load wins over count; a simultaneous incr and decr leaves the value unchanged;
// decr at zero holds at zero so the count never underflows.
module KDarwin_counter
  import kdarwin_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             load,
  input  logic             incr,
  input  logic             decr,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             is_zero
);

  logic [WIDTH-1:0] count_reg;

  // Count register: load, increment or saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clken) begin
      if (load) begin
        count_reg <= load_value;
      end else if (incr && !decr) begin
        count_reg <= count_reg + WIDTH'(1);
      end else if (decr && !incr && (count_reg != '0)) begin
        count_reg <= count_reg - WIDTH'(1);
      end
    end
  end

  assign count   = count_reg;
  assign is_zero = (count_reg == '0);

endmodule

// File: rtl/kdarwin_rd_burst_ctrl.sv
// AXI4 read-address scheduler: splits a byte transfer into fixed-length
// bursts, issues them under an outstanding-burst credit limit and reports
// completion once every burst's rlast has come back.
module kdarwin_rd_burst_ctrl
  import kdarwin_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  output logic                         ctrl_err,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  input  logic                         m_axi_rready,
  input  logic                         m_axi_rlast
);

  localparam int LP_BPB   = C_DATA_WIDTH / 8;
  localparam int LP_CNT_W = C_XFER_SIZE_WIDTH;
  localparam int LP_OUT_W = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_ADDR_WIDTH-1:0] LP_BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * LP_BPB);
  localparam logic [7:0]              LP_FULL_LEN    = 8'(C_BURST_LEN - 1);
  localparam logic [LP_OUT_W-1:0]     LP_MAX_OUT     = LP_OUT_W'(C_MAX_OUTSTANDING);
  localparam logic [LP_OUT_W-1:0]     LP_MAX_OUT_M1  = LP_OUT_W'(C_MAX_OUTSTANDING - 1);

  if ((C_BURST_LEN < 1) || (C_BURST_LEN > 256)) begin : g_bad_burst_len
    $error("C_BURST_LEN must be within 1..256");
  end
  if ((C_BURST_LEN * LP_BPB) > LP_MAX_BURST_BYTES) begin : g_bad_burst_bytes
    $error("C_BURST_LEN * bytes-per-beat exceeds the 4 KiB AXI burst limit");
  end
  if (C_MAX_OUTSTANDING < 1) begin : g_bad_outstanding
    $error("C_MAX_OUTSTANDING must be at least 1");
  end

  rd_burst_state_t             state_reg;
  logic [C_ADDR_WIDTH-1:0]     addr_reg;
  logic [LP_CNT_W-1:0]         size_reg;
  logic [7:0]                  last_len_reg;
  logic                        busy_reg;
  logic                        done_reg;
  logic                        err_reg;
  logic                        arvalid_reg;
  logic [C_ADDR_WIDTH-1:0]     araddr_reg;
  logic [7:0]                  arlen_reg;

  logic [LP_CNT_W-1:0]         num_beats_calc;
  logic [LP_CNT_W-1:0]         num_bursts_calc;
  logic [7:0]                  last_len_calc;
  logic [LP_CNT_W-1:0]         ar_rem;
  logic [LP_CNT_W-1:0]         r_rem;
  logic [LP_OUT_W-1:0]         out_cnt;
  logic                        ar_is_zero;
  logic                        r_is_zero;
  logic                        out_is_zero;
  logic                        ar_hs;
  logic                        r_last_hs;
  logic                        r_dec;
  logic                        r_err_evt;
  logic                        start_accept;
  logic                        calc_load;
  logic                        credit_next_ok;

  assign ar_hs        = m_axi_arvalid & m_axi_arready;
  assign r_last_hs    = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  // An rlast only retires a burst if one is actually in flight.
  assign r_dec        = r_last_hs & ~out_is_zero;
  assign r_err_evt    = r_last_hs & out_is_zero;
  assign start_accept = (state_reg == IDLE) & ctrl_start;
  assign calc_load    = (state_reg == CALC);

  assign num_beats_calc  = LP_CNT_W'(ceil_div(64'(size_reg), 64'(LP_BPB)));
  assign num_bursts_calc = LP_CNT_W'(ceil_div(64'(num_beats_calc), 64'(C_BURST_LEN)));
  assign last_len_calc   = 8'((64'(num_beats_calc) - 64'd1) % 64'(C_BURST_LEN));

  // Credit check against the outstanding count as it will be after this edge.
  always_comb begin
    credit_next_ok = 1'b0;
    if (ar_hs && !r_dec) begin
      credit_next_ok = (out_cnt < LP_MAX_OUT_M1);
    end else if (r_dec && !ar_hs) begin
      credit_next_ok = 1'b1;
    end else begin
      credit_next_ok = (out_cnt < LP_MAX_OUT);
    end
  end

  KDarwin_counter #(.WIDTH(LP_CNT_W)) u_ar_remaining (
    .clk(clk), .rst(rst), .clken(1'b1),
    .load(calc_load), .incr(1'b0), .decr(ar_hs),
    .load_value(num_bursts_calc), .count(ar_rem), .is_zero(ar_is_zero)
  );

  KDarwin_counter #(.WIDTH(LP_CNT_W)) u_r_remaining (
    .clk(clk), .rst(rst), .clken(1'b1),
    .load(calc_load), .incr(1'b0), .decr(r_dec),
    .load_value(num_bursts_calc), .count(r_rem), .is_zero(r_is_zero)
  );

  KDarwin_counter #(.WIDTH(LP_OUT_W)) u_outstanding (
    .clk(clk), .rst(rst), .clken(1'b1),
    .load(1'b0), .incr(ar_hs), .decr(r_dec),
    .load_value('0), .count(out_cnt), .is_zero(out_is_zero)
  );

  // Control FSM with registered AR channel, address generator and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      size_reg     <= '0;
      last_len_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      arvalid_reg  <= 1'b0;
      araddr_reg   <= '0;
      arlen_reg    <= '0;
    end else begin
      // Sticky error; an accepted start clears it unless a new stray rlast lands now.
      err_reg <= (err_reg & ~start_accept) | r_err_evt;
      case (state_reg)
        IDLE: begin
          if (ctrl_start) begin
            addr_reg  <= ctrl_addr_offset;
            size_reg  <= ctrl_xfer_size_in_bytes;
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          last_len_reg <= last_len_calc;
          araddr_reg   <= addr_reg;
          arlen_reg    <= (num_bursts_calc == LP_CNT_W'(1)) ? last_len_calc : LP_FULL_LEN;
          if (num_bursts_calc == '0) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            arvalid_reg <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_hs && (ar_rem == LP_CNT_W'(1))) begin
            arvalid_reg <= 1'b0;
            state_reg   <= DRAIN;
          end else begin
            if (ar_hs) begin
              araddr_reg <= araddr_reg + LP_BURST_BYTES;
              arlen_reg  <= (ar_rem == LP_CNT_W'(2)) ? last_len_reg : LP_FULL_LEN;
            end
            // A pending request is held until accepted; otherwise re-arm on credit.
            if (!arvalid_reg || ar_hs) begin
              arvalid_reg <= credit_next_ok && !ar_is_zero;
            end
          end
        end
        DRAIN: begin
          if ((r_dec && (r_rem == LP_CNT_W'(1))) || r_is_zero) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ctrl_busy     = busy_reg;
  assign ctrl_done     = done_reg;
  assign ctrl_err      = err_reg;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arlen   = arlen_reg;

endmodule

// File: tb/tb_kdarwin_rd_burst_ctrl.sv
// Scoreboard bench for kdarwin_rd_burst_ctrl (512-bit data, 64-beat bursts,
// two outstanding bursts). Stimulus pushes expected ARs and done events;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_kdarwin_rd_burst_ctrl;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_start = 1'b0;
  logic [63:0] ctrl_addr_offset = '0;
  logic [31:0] ctrl_xfer_size_in_bytes = '0;
  logic        ctrl_busy, ctrl_done, ctrl_err;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready = 1'b0;
  logic        m_axi_rlast = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_r_cyc = -100;
  int ar_hs_cnt = 0;
  int done_seen = 0;
  int ar_mode = 0;      // 0: arready high, 1: random, 2: arready low
  int r_auto = 1;       // 1: rlast one cycle after each AR, 0: on request
  int r_ack_base = 0;
  int r_sent_auto = 0;
  int r_man_req = 0;
  int r_man_done = 0;

  ar_t exp_ar_q[$];
  int  exp_done_q[$];   // 0: one cycle after last rlast, 1: start + 2

  kdarwin_rd_burst_ctrl #(
    .C_ADDR_WIDTH(64), .C_DATA_WIDTH(512), .C_XFER_SIZE_WIDTH(32),
    .C_BURST_LEN(64), .C_MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ar(input logic [63:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_ar_q.push_back(e);
  endtask

  // Drives a one-cycle start; returns #1 into cycle t+1.
  task automatic start_xfer(input logic [63:0] off, input logic [31:0] sz);
    @(posedge clk);
    #1;
    ctrl_start = 1'b1;
    ctrl_addr_offset = off;
    ctrl_xfer_size_in_bytes = sz;
    start_cyc = cyc;
    tick(1);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    int k = 0;
    while (done_seen == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, 64'(done_seen != d0), 64'd1);
  endtask

  task automatic auto_r_on();
    r_auto = 1;
    r_ack_base = ar_hs_cnt - r_sent_auto;
  endtask

  // arready driver
  initial forever begin
    @(posedge clk);
    #1;
    if (ar_mode == 0)      m_axi_arready = 1'b1;
    else if (ar_mode == 1) m_axi_arready = 1'($urandom_range(0, 1));
    else                   m_axi_arready = 1'b0;
  end

  // R-channel last-beat responder
  initial forever begin
    @(posedge clk);
    #1;
    if ((r_auto != 0) ? (ar_hs_cnt - r_ack_base - r_sent_auto > 0) : (r_man_req > r_man_done)) begin
      m_axi_rvalid = 1'b1;
      m_axi_rready = 1'b1;
      m_axi_rlast  = 1'b1;
      if (r_auto != 0) r_sent_auto++;
      else r_man_done++;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rready = 1'b0;
      m_axi_rlast  = 1'b0;
    end
  end

  // Monitor: AR scoreboard, AR stability, done timing
  initial begin
    logic        hold_v;
    logic [63:0] hold_addr;
    logic [7:0]  hold_len;
    ar_t         e;
    int          kind;
    hold_v = 1'b0;
    hold_addr = '0;
    hold_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast) last_r_cyc = cyc;
        if (hold_v) begin
          check("arvalid_held", 64'(m_axi_arvalid), 64'd1);
          if (m_axi_arvalid) begin
            check("araddr_stable", m_axi_araddr, hold_addr);
            check("arlen_stable", 64'(m_axi_arlen), 64'(hold_len));
          end
        end
        if (m_axi_arvalid && m_axi_arready) begin
          $display("AR  cycle %0d addr=%h len=%0d", cyc, m_axi_araddr, m_axi_arlen);
          if (exp_ar_q.size() == 0) begin
            check("ar_unexpected", m_axi_araddr, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            e = exp_ar_q.pop_front();
            check("ar_addr", m_axi_araddr, e.addr);
            check("ar_len", 64'(m_axi_arlen), 64'(e.len));
          end
          ar_hs_cnt++;
        end
        hold_v    = m_axi_arvalid && !m_axi_arready;
        hold_addr = m_axi_araddr;
        hold_len  = m_axi_arlen;
        if (ctrl_done) begin
          $display("DONE cycle %0d", cyc);
          if (exp_done_q.size() == 0) begin
            check("done_unexpected", 64'(cyc), 64'hFFFF_FFFF);
          end else begin
            kind = exp_done_q.pop_front();
            check("done_cycle", 64'(cyc), 64'((kind == 1) ? start_cyc + 2 : last_r_cyc + 1));
          end
          done_seen++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int d0;
    int b0;
    tick(3);
    rst = 1'b0;
    check("rst_busy", 64'(ctrl_busy), 64'd0);
    check("rst_done", 64'(ctrl_done), 64'd0);
    check("rst_err", 64'(ctrl_err), 64'd0);
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_arlen", 64'(m_axi_arlen), 64'd0);

    // Single full burst, immediate R
    auto_r_on();
    push_ar(64'h0000_0000_1000_0000, 8'd63);
    exp_done_q.push_back(0);
    d0 = done_seen;
    start_xfer(64'h0000_0000_1000_0000, 32'd4096);
    check("t1_busy_calc", 64'(ctrl_busy), 64'd1);
    check("t1_arvalid_calc", 64'(m_axi_arvalid), 64'd0);
    tick(1);
    check("t1_arvalid_t2", 64'(m_axi_arvalid), 64'd1);
    wait_done("t1_done", d0, 200);
    check("t1_busy_fall", 64'(ctrl_busy), 64'd0);
    check("t1_ar_drained", 64'(exp_ar_q.size()), 64'd0);

    // 8256 bytes: two full bursts plus a one-beat tail
    push_ar(64'h0000_0000_2000_0040, 8'd63);
    push_ar(64'h0000_0000_2000_1040, 8'd63);
    push_ar(64'h0000_0000_2000_2040, 8'd0);
    exp_done_q.push_back(0);
    d0 = done_seen;
    start_xfer(64'h0000_0000_2000_0040, 32'd8256);
    wait_done("t2_done", d0, 200);
    check("t2_ar_drained", 64'(exp_ar_q.size()), 64'd0);

    // Credit limit: 16484 bytes -> 258 beats -> 5 bursts, R withheld
    r_auto = 0;
    b0 = ar_hs_cnt;
    for (int k = 0; k < 5; k++) push_ar(64'(k) * 64'd4096, (k == 4) ? 8'd1 : 8'd63);
    exp_done_q.push_back(0);
    start_xfer(64'h0, 32'd16484);
    tick(10);
    check("t3_ar_before_r", 64'(ar_hs_cnt - b0), 64'd2);
    check("t3_arvalid_starved", 64'(m_axi_arvalid), 64'd0);
    for (int k = 3; k <= 5; k++) begin
      r_man_req++;
      tick(6);
      check("t3_ar_per_rlast", 64'(ar_hs_cnt - b0), 64'(k));
      check("t3_arvalid_low", 64'(m_axi_arvalid), 64'd0);
    end
    d0 = done_seen;
    r_man_req++;
    tick(6);
    check("t3_busy_before_last", 64'(ctrl_busy), 64'd1);
    check("t3_no_early_done", 64'(done_seen), 64'(d0));
    r_man_req++;
    wait_done("t3_done", d0, 100);
    check("t3_ar_drained", 64'(exp_ar_q.size()), 64'd0);

    // Random arready with address wrap across 2^64
    auto_r_on();
    ar_mode = 1;
    push_ar(64'hFFFF_FFFF_FFFF_E000, 8'd63);
    push_ar(64'hFFFF_FFFF_FFFF_F000, 8'd63);
    push_ar(64'h0000_0000_0000_0000, 8'd63);
    push_ar(64'h0000_0000_0000_1000, 8'd63);
    push_ar(64'h0000_0000_0000_2000, 8'd63);
    exp_done_q.push_back(0);
    d0 = done_seen;
    start_xfer(64'hFFFF_FFFF_FFFF_E000, 32'd20480);
    wait_done("t4_done", d0, 600);
    check("t4_ar_drained", 64'(exp_ar_q.size()), 64'd0);
    ar_mode = 0;

    // Stray rlast while idle, then a zero-size transfer
    r_auto = 0;
    tick(2);
    r_man_req++;
    tick(4);
    check("t5_err_set", 64'(ctrl_err), 64'd1);
    b0 = ar_hs_cnt;
    exp_done_q.push_back(1);
    d0 = done_seen;
    start_xfer(64'h0000_0000_4000_0000, 32'd0);
    check("t5_err_cleared", 64'(ctrl_err), 64'd0);
    check("t5_arvalid_calc", 64'(m_axi_arvalid), 64'd0);
    tick(1);
    check("t5_arvalid_t2", 64'(m_axi_arvalid), 64'd0);
    check("t5_done_t2", 64'(ctrl_done), 64'd1);
    wait_done("t5_done", d0, 20);
    tick(3);
    check("t5_no_ar", 64'(ar_hs_cnt - b0), 64'd0);

    // Reset mid-operation with an AR pending
    b0 = ar_hs_cnt;
    for (int k = 0; k < 4; k++) push_ar(64'h0000_0000_3000_0000 + 64'(k) * 64'd4096, 8'd63);
    exp_done_q.push_back(0);
    d0 = done_seen;
    start_xfer(64'h0000_0000_3000_0000, 32'd16384);
    tick(8);
    check("t6_ar_before_rst", 64'(ar_hs_cnt - b0), 64'd2);
    ar_mode = 2;
    r_man_req++;
    tick(5);
    check("t6_arvalid_pending", 64'(m_axi_arvalid), 64'd1);
    check("t6_araddr_pending", m_axi_araddr, 64'h0000_0000_3000_2000);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_ar_q.delete();
    exp_done_q.delete();
    check("t6_arvalid_after_rst", 64'(m_axi_arvalid), 64'd0);
    check("t6_busy_after_rst", 64'(ctrl_busy), 64'd0);
    check("t6_araddr_after_rst", m_axi_araddr, 64'd0);
    tick(10);
    check("t6_no_done", 64'(done_seen), 64'(d0));

    // Fresh start after reset
    ar_mode = 0;
    auto_r_on();
    push_ar(64'h0000_0000_0000_0040, 8'd63);
    exp_done_q.push_back(0);
    d0 = done_seen;
    start_xfer(64'h0000_0000_0000_0040, 32'd4096);
    check("t7_busy", 64'(ctrl_busy), 64'd1);
    wait_done("t7_done", d0, 200);
    check("t7_busy_fall", 64'(ctrl_busy), 64'd0);
    check("t7_ar_drained", 64'(exp_ar_q.size()), 64'd0);
    check("t7_done_q_empty", 64'(exp_done_q.size()), 64'd0);
    check("t7_err", 64'(ctrl_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
